inst_mem_resp: RTL and testbench
================================

Name: inst_mem_resp

Overview:
- Instruction-memory responder on the fetch interface: takes the fetch-stage PC byte address and returns the 32-bit instruction one cycle later with a valid strobe.
- Also contains a byte-serial program loader FSM that fills the memory at boot or from the testbench.
- Fetches are held off (ready low) while a load is in progress.
- Sits between the fetch stage and the decode stage.

Parameters:
- DEPTH_LOG2, 8, log2 of memory depth in 32-bit words (default 256 words).
- NOP_WORD, 32'h00000013, word returned for out-of-range fetches (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  fetch request, qualified by ready.
- addr  in  32  fetch byte address (`InstAddrBus width).
- ready  out  1  responder can accept req this cycle.
- rvalid  out  1  rdata valid, one cycle after accepted req.
- rdata  out  32  instruction word.
- rerr  out  1  fetch error, valid with rvalid.
- ld_start  in  1  pulse: begin program load at word 0.
- ld_valid  in  1  ld_byte valid this cycle.
- ld_byte  in  8  program byte, little-endian order.
- ld_done  in  1  pulse: end of program stream.
- ld_busy  out  1  loader not idle.
- ld_ovf  out  1  sticky: load wrapped past last word.

Behaviour:
- Reset: asynchronous, active-low; clk/rst_n only, one clock domain. rst_n low → ready=0, rvalid=0, rdata=0, rerr=0, ld_busy=0, ld_ovf=0, loader FSM=L_IDLE, byte lane=0, word pointer=0. Memory contents are not cleared. Reset mid-load or mid-fetch drops the in-flight response and the partial word.
- Fetch path:
  - ready = (FSM==L_IDLE) && !ld_start. A request is accepted when req && ready.
  - Latency is exactly 1 cycle. In cycle N+1 after acceptance: rvalid=1, rdata=mem[addr[DEPTH_LOG2+1:2]].
  - Back-to-back accepts give one rvalid per cycle with no bubble.
  - No request accepted → rvalid=0 next cycle and rdata holds its last value.
  - Out-of-range fetch: addr[31:DEPTH_LOG2+2] != 0 → rdata=NOP_WORD, rerr=1.
  - An in-range read of a location written in the same cycle returns the old data (read-before-write).
- Loader FSM states:
  - L_IDLE: ld_start → L_BYTES; clears the word pointer and byte lane but not ld_ovf. ld_start wins over a simultaneous req, which is not accepted.
  - L_BYTES: each ld_valid shifts ld_byte into lane (lane 0 = bits 7:0). After lane 3 is filled, the full word is written to mem[ptr] in the same cycle as the 4th byte, ptr increments and lane returns to 0.
    - ptr wraps from 2^DEPTH_LOG2-1 to 0 and sets ld_ovf.
    - ld_done with lane != 0 → L_FLUSH.
    - ld_done with lane == 0 → L_IDLE.
    - ld_done and ld_valid in the same cycle: the byte is consumed first, then the ld_done rule is evaluated on the updated lane.
    - ld_start while in L_BYTES restarts at ptr=0 and discards the partial word.
  - L_FLUSH: writes the partial word with upper lanes zero-padded, ptr++ (with wrap rule), → L_IDLE. Lasts 1 cycle.
  - ld_busy = (FSM != L_IDLE).
- ld_ovf clears only on reset.

Optional Feature:
- Macro IMEM_MISALIGN_TRAP_EN.
- Defined: a fetch with addr[1:0] != 0 returns rdata=NOP_WORD and rerr=1 with normal 1-cycle latency. The out-of-range check also applies.
- Undefined: addr[1:0] is ignored, the word at addr[DEPTH_LOG2+1:2] is returned, and misalignment never causes rerr.

Test Plan:
- Load then fetch: pulse ld_start, stream bytes 13,05,10,00 then 93,00,20,00, pulse ld_done → mem[0]=32'h00100513, mem[1]=32'h00200093. Then req addr=0 then addr=4 on consecutive cycles → rvalid on the next two cycles with those words, rerr=0.
- Partial flush: load 5 bytes AA,BB,CC,DD,EE then ld_done → mem[1]=32'h000000EE; ld_busy is high through L_FLUSH then drops; ready returns 1 the cycle after.
- Out-of-range: DEPTH_LOG2=8, req addr=32'h00000400 → rdata=32'h00000013, rerr=1.
- Contention: ld_start and req asserted in the same cycle → ready=0, no rvalid next cycle, FSM=L_BYTES.
- Wrap: DEPTH_LOG2=2, load 20 bytes → ld_ovf=1 and mem[0] holds bytes 16..19.
- Async reset mid-load: assert rst_n low between edges after 2 bytes → outputs zero immediately. After release, a fetch of addr=0 returns the pre-load contents. With IMEM_MISALIGN_TRAP_EN, addr=2 → rerr=1 and NOP_WORD.

Source files
------------

// File: rtl/inst_mem_resp_if.sv
// inst_mem_resp_if: fetch-side handshake between the fetch stage and the instruction memory responder.
interface inst_mem_resp_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rerr;

    modport master (output req, addr, input ready, rvalid, rdata, rerr);
    modport slave  (input req, addr, output ready, rvalid, rdata, rerr);
endinterface

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: 1-cycle instruction fetch responder with a byte-serial program loader.
// Define IMEM_MISALIGN_TRAP_EN to make fetches with addr[1:0] != 0 return NOP_WORD with rerr.
module inst_mem_resp #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inst_mem_resp_if.slave        fetch,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_done,
    output logic                  ld_busy,
    output logic                  ld_ovf
);
`ifdef IMEM_MISALIGN_TRAP_EN
    localparam bit TRAP_MISALIGN = 1'b1;
`else
    localparam bit TRAP_MISALIGN = 1'b0;
`endif
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {L_IDLE, L_BYTES, L_FLUSH} ld_state_e;

    ld_state_e             state_q, state_d;
    logic [1:0]            lane_q, lane_d, lane_n;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [31:0]           word_q, word_d;
    logic                  ovf_q, ovf_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rerr_q, rerr_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic                  we, accept, bad;
    logic [31:0]           wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= L_IDLE;
            lane_q   <= '0;
            ptr_q    <= '0;
            word_q   <= '0;
            ovf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            ptr_q    <= ptr_d;
            word_q   <= word_d;
            ovf_q    <= ovf_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
        end
    end

    // Memory is not reset; reads in the fetch path see the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) mem[ptr_q] <= wdata;
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        lane_n  = lane_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        wdata   = word_q;
        unique case (state_q)
            L_IDLE: begin
                if (ld_start) begin
                    state_d = L_BYTES;
                    lane_d  = '0;
                    ptr_d   = '0;
                    word_d  = '0;
                end
            end
            L_BYTES: begin
                if (ld_start) begin
                    lane_d = '0;
                    ptr_d  = '0;
                    word_d = '0;
                end else begin
                    if (ld_valid) begin
                        if (lane_q == 2'd3) begin
                            we     = 1'b1;
                            wdata  = {ld_byte, word_q[23:0]};
                            word_d = '0;
                        end else begin
                            word_d[{lane_q, 3'b000} +: 8] = ld_byte;
                        end
                        lane_n = lane_q + 2'd1;
                    end
                    lane_d = lane_n;
                    if (ld_done) state_d = (lane_n != 2'd0) ? L_FLUSH : L_IDLE;
                end
            end
            L_FLUSH: begin
                we      = 1'b1;
                lane_d  = '0;
                word_d  = '0;
                state_d = L_IDLE;
            end
            default: state_d = L_IDLE;
        endcase
        if (we) begin
            ptr_d = ptr_q + PTR_ONE;
            ovf_d = ovf_q | (&ptr_q);
        end
    end

    always_comb begin
        bad      = (|fetch.addr[31:DEPTH_LOG2+2]) | (TRAP_MISALIGN & (|fetch.addr[1:0]));
        rvalid_d = accept;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        if (accept) begin
            rdata_d = bad ? NOP_WORD : mem[fetch.addr[DEPTH_LOG2+1:2]];
            rerr_d  = bad;
        end
    end

    always_comb begin
        ld_busy     = state_q != L_IDLE;
        fetch.ready = rst_n && !ld_busy && !ld_start;
        accept      = fetch.req && fetch.ready;
    end

    assign fetch.rvalid = rvalid_q;
    assign fetch.rdata  = rdata_q;
    assign fetch.rerr   = rerr_q;
    assign ld_ovf       = ovf_q;
endmodule

// File: tb/tb_inst_mem_resp.sv
// tb_inst_mem_resp: randomized load/fetch bench against a word-level memory model.
module tb_inst_mem_resp;
    localparam int          D   = 256;
    localparam logic [31:0] NOP = 32'h00000013;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_start = 1'b0, ld_valid = 1'b0, ld_done = 1'b0;
    logic [7:0] ld_byte = '0;
    logic       ld_busy, ld_ovf;

    inst_mem_resp_if bus();

    inst_mem_resp #(.DEPTH_LOG2(8), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .fetch(bus),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_done(ld_done),
        .ld_busy(ld_busy), .ld_ovf(ld_ovf)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_err = 0;
    logic [31:0] mem_m [D];
    logic        ovf_m = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic        exp_rerr = 1'b0;
    logic [7:0]  byte_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] ref_word(input logic [31:0] a);
        if (a >= 32'(4 * D)) return {1'b1, NOP};
`ifdef IMEM_MISALIGN_TRAP_EN
        if (a % 4 != 0) return {1'b1, NOP};
`endif
        return {1'b0, mem_m[int'(a >> 2)]};
    endfunction

    // Apply a byte stream to the model: words land from index 0 upward, modulo depth.
    function automatic void commit(input int n, input bit partial);
        int nw = partial ? (n + 3) / 4 : n / 4;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] word = '0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < n) word[8*k +: 8] = byte_q[4*w+k];
            mem_m[w % D] = word;
        end
        if (nw > D) ovf_m = 1'b1;
    endfunction

    task automatic fetch(input bit r, input logic [31:0] a);
        bus.req  = r;
        bus.addr = a;
        #1 chk("ready_idle", bus.ready, 1);
        cyc();
        chk("rvalid", bus.rvalid, r);
        if (r) {exp_rerr, exp_rdata} = ref_word(a);
        chk("rdata", bus.rdata, exp_rdata);
        chk("rerr", bus.rerr, exp_rerr);
        bus.req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a = 32'($urandom_range(255)) << 2;
        case ($urandom_range(9))
            0: a = $urandom | 32'h400;
            1: a = a | 32'($urandom_range(3, 1));
            2: a = 32'h3FC;
            3: a = 32'h400;
            default: ;
        endcase
        return a;
    endfunction

    task automatic send_bytes(input bit done_last, input bit gaps);
        for (int i = 0; i < byte_q.size(); i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                ld_valid = 1'b0;
                cyc();
            end
            ld_valid = 1'b1;
            ld_byte  = byte_q[i];
            ld_done  = done_last && (i == byte_q.size() - 1);
            cyc();
        end
        ld_valid = 1'b0;
        ld_done  = 1'b0;
    endtask

    task automatic load(input bit done_last, input bit gaps);
        ld_start = 1'b1;
        bus.req  = 1'($urandom_range(1));
        #1 chk("ready_ld_start", bus.ready, 0);
        cyc();
        chk("rvalid_contend", bus.rvalid, 0);
        chk("busy_start", ld_busy, 1);
        ld_start = 1'b0;
        bus.req  = 1'b0;
        send_bytes(done_last, gaps);
        if (!done_last) begin
            ld_done = 1'b1;
            cyc();
            ld_done = 1'b0;
        end
        if (byte_q.size() % 4 != 0) begin
            chk("busy_flush", ld_busy, 1);
            cyc();
        end
        chk("busy_idle", ld_busy, 0);
        #1 chk("ready_after_load", bus.ready, 1);
        commit(byte_q.size(), 1'b1);
        chk("ld_ovf", ld_ovf, ovf_m);
    endtask

    task automatic random_fetches(input int n);
        for (int i = 0; i < n; i++) fetch(1'($urandom_range(3) != 0), rand_addr());
    endtask

    initial begin
        bus.req  = 1'b0;
        bus.addr = '0;
        #1;
        chk("rst_ready", bus.ready, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_busy", ld_busy, 0);
        chk("rst_ovf", ld_ovf, 0);
        #12 rst_n = 1'b1;
        cyc();

        // Fill every word and wrap four bytes past the end.
        byte_q.delete();
        for (int i = 0; i < 4 * D + 4; i++) byte_q.push_back(8'($urandom));
        load(1'($urandom_range(1)), 1'b1);
        chk("ovf_after_wrap", ld_ovf, 1);
        random_fetches(150);

        byte_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
        load(1'b0, 1'b0);
        fetch(1'b1, 32'h0);
        chk("mem0_const", bus.rdata, 32'h00100513);
        fetch(1'b1, 32'h4);
        chk("mem1_const", bus.rdata, 32'h00200093);
        fetch(1'b0, 32'h4);

        byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        load(1'b0, 1'b0);
        fetch(1'b1, 32'h4);
        chk("flush_word", bus.rdata, 32'h000000EE);
        fetch(1'b1, 32'h0);
        chk("flush_word0", bus.rdata, 32'hDDCCBBAA);

        fetch(1'b1, 32'h400);
        chk("oor_rdata", bus.rdata, NOP);
        chk("oor_rerr", bus.rerr, 1);
        random_fetches(150);

        // Contention with ld_start, then a restart that keeps only completed words.
        byte_q.delete();
        for (int i = 0; i < 6; i++) byte_q.push_back(8'($urandom));
        ld_start = 1'b1;
        bus.req  = 1'b1;
        bus.addr = 32'h8;
        #1 chk("contend_ready", bus.ready, 0);
        cyc();
        chk("contend_rvalid", bus.rvalid, 0);
        chk("contend_busy", ld_busy, 1);
        ld_start = 1'b0;
        bus.req  = 1'b0;
        send_bytes(1'b0, 1'b1);
        commit(6, 1'b0);
        byte_q.delete();
        for (int i = 0; i < 9; i++) byte_q.push_back(8'($urandom));
        load(1'b1, 1'b1);
        random_fetches(150);

        // Reset in the middle of a load.
        byte_q = '{8'h11, 8'h22};
        ld_start = 1'b1;
        cyc();
        ld_start = 1'b0;
        send_bytes(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("amid_ready", bus.ready, 0);
        chk("amid_rvalid", bus.rvalid, 0);
        chk("amid_rdata", bus.rdata, 0);
        chk("amid_rerr", bus.rerr, 0);
        chk("amid_busy", ld_busy, 0);
        chk("amid_ovf", ld_ovf, 0);
        ovf_m     = 1'b0;
        exp_rdata = '0;
        exp_rerr  = 1'b0;
        #3 rst_n = 1'b1;
        cyc();
        fetch(1'b1, 32'h0);
        fetch(1'b1, 32'h2);
        fetch(1'b0, 32'h0);
        chk("ovf_post_rst", ld_ovf, 0);
        random_fetches(50);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL timeout: simulation did not reach the end");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
